// File: rtl/axis_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axis_pkg                                                |
// | Purpose  : Shared constants for the stream read/write engines and |
// |            their command front-ends: FSM state indices and the     |
// |            default config-bus register map.                        |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package axis_pkg;

  // Bit positions of the one-hot command-serialiser states
  localparam int unsigned ST_IDLE  = 0;
  localparam int unsigned ST_SEL   = 1;
  localparam int unsigned ST_ADR   = 2;
  localparam int unsigned ST_LEN   = 3;
  localparam int unsigned ST_COUNT = 4;

  // Default config-bus register map shared by the read and write engines
  localparam logic [4:0] CFG_SEL_REG  = 5'd23;
  localparam logic [4:0] CFG_DATA_REG = 5'd24;

  // One-hot encoding of the serialiser states
  typedef enum logic [ST_COUNT-1:0] {
    S_IDLE = 4'(1 << ST_IDLE),
    S_SEL  = 4'(1 << ST_SEL),
    S_ADR  = 4'(1 << ST_ADR),
    S_LEN  = 4'(1 << ST_LEN)
  } cmd_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axis_cmd_fifo                                           |
// | Purpose  : Small synchronous show-ahead FIFO with full/empty flags |
// |            and an occupancy count. Writes to a full FIFO and reads |
// |            from an empty FIFO are ignored.                         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module axis_cmd_fifo #(
  parameter int WIDTH  = 64,
  parameter int AWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AWIDTH:0]   o_count
);

  localparam int              c_depth      = 1 << AWIDTH;
  localparam logic [AWIDTH:0] c_full_count = (AWIDTH+1)'(c_depth);
  localparam logic [AWIDTH:0] c_count_one  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] c_ptr_one  = AWIDTH'(1);

  logic [WIDTH-1:0]  r_mem [c_depth];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;

  logic w_wr;
  logic w_rd;

  assign o_full    = (r_count == c_full_count);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & ~o_empty;

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and read leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + c_count_one;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - c_count_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_read_cmd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axis_read_cmd                                           |
// | Purpose  : Read-command front-end. Queues (address, length)        |
// |            commands, serialises each one onto the config bus as    |
// |            select / address / length beats, and pulses done as the |
// |            engine's output stream consumes each command in order.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module axis_read_cmd
  import axis_pkg::*;
#(
  parameter int CFG_ID     = 1,
  parameter int CFG_ADDR   = int'(CFG_SEL_REG),
  parameter int CFG_DATA   = int'(CFG_DATA_REG),
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  parameter int CMD_AWIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cmd_address,
  input  logic [CFG_DWIDTH-1:0] cmd_length,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  input  logic                  strm_valid,
  input  logic                  strm_ready,
  output logic                  done,
  output logic                  busy,
  output logic                  err_unexp
);

  localparam int                    c_cmd_w     = 2 * CFG_DWIDTH;
  localparam logic [CMD_AWIDTH:0]   c_len_depth = (CMD_AWIDTH+1)'(1 << CMD_AWIDTH);
  localparam logic [CMD_AWIDTH:0]   c_len_one   = (CMD_AWIDTH+1)'(1);
  localparam logic [CFG_AWIDTH-1:0] c_sel_addr  = CFG_AWIDTH'(CFG_ADDR);
  localparam logic [CFG_AWIDTH-1:0] c_data_addr = CFG_AWIDTH'(CFG_DATA);
  localparam logic [CFG_DWIDTH-1:0] c_id        = CFG_DWIDTH'(CFG_ID);
  localparam logic [CFG_DWIDTH-1:0] c_cnt_one   = CFG_DWIDTH'(1);

  // Command queue
  logic                  w_cmd_wr;
  logic                  w_cmd_rd;
  logic [c_cmd_w-1:0]    w_cmd_head;
  logic                  w_cmd_full;
  logic                  w_cmd_empty;
  logic [CMD_AWIDTH:0]   w_cmd_count;
  logic [CFG_DWIDTH-1:0] w_head_addr;
  logic [CFG_DWIDTH-1:0] w_head_len;
  logic                  w_head_zero;

  // Pending-length queue
  logic                  w_len_push;
  logic                  w_len_pop;
  logic [CFG_DWIDTH-1:0] w_len_head;
  logic                  w_len_full;
  logic                  w_len_empty;
  logic [CMD_AWIDTH:0]   w_len_count;
  logic [CMD_AWIDTH:0]   w_len_after;

  // Serialiser control
  logic                  w_len_accept;
  logic                  w_idle_issue;
  logic                  w_idle_drop;
  logic                  w_chain;

  // Completion tracking
  logic                  w_beat;
  logic [CFG_DWIDTH-1:0] w_cnt_inc;

  cmd_state_t            r_state;
  logic [CFG_DWIDTH-1:0] r_hold_addr;
  logic [CFG_DWIDTH-1:0] r_hold_len;
  logic                  r_cfg_valid;
  logic [CFG_AWIDTH-1:0] r_cfg_addr;
  logic [CFG_DWIDTH-1:0] r_cfg_data;
  logic [CFG_DWIDTH-1:0] r_beat_cnt;
  logic                  r_done;
  logic                  r_err;
  logic                  r_busy;

  // The queue is held closed while rst is asserted so nothing is captured during reset
  assign cmd_ready = ~rst & ~w_cmd_full;
  assign w_cmd_wr  = cmd_valid & cmd_ready;

  assign w_head_addr = w_cmd_head[c_cmd_w-1:CFG_DWIDTH];
  assign w_head_len  = w_cmd_head[CFG_DWIDTH-1:0];
  assign w_head_zero = (w_head_len == '0);

  // Zero-length commands are popped and discarded straight from IDLE
  assign w_len_accept = (r_state == S_LEN) && cfg_ready;
  assign w_idle_drop  = (r_state == S_IDLE) && !w_cmd_empty && w_head_zero;
  assign w_idle_issue = (r_state == S_IDLE) && !w_cmd_empty && !w_head_zero && !w_len_full;

  // Occupancy of the length queue once this cycle's push and pop have both landed
  assign w_len_after = w_len_count + c_len_one - {{CMD_AWIDTH{1'b0}}, w_len_pop};
  assign w_chain     = w_len_accept && !w_cmd_empty && !w_head_zero && (w_len_after < c_len_depth);
  assign w_cmd_rd    = w_idle_drop | w_idle_issue | w_chain;
  assign w_len_push  = w_len_accept;

  assign w_beat    = strm_valid & strm_ready;
  assign w_cnt_inc = r_beat_cnt + c_cnt_one;
  assign w_len_pop = w_beat && !w_len_empty && (w_cnt_inc == w_len_head);

  assign cfg_valid = r_cfg_valid;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign done      = r_done;
  assign busy      = r_busy;
  assign err_unexp = r_err;

  axis_cmd_fifo #(
    .WIDTH  (c_cmd_w),
    .AWIDTH (CMD_AWIDTH)
  ) u_cmd_q (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_cmd_wr),
    .i_wr_data ({cmd_address, cmd_length}),
    .i_rd_en   (w_cmd_rd),
    .o_rd_data (w_cmd_head),
    .o_full    (w_cmd_full),
    .o_empty   (w_cmd_empty),
    .o_count   (w_cmd_count)
  );

  axis_cmd_fifo #(
    .WIDTH  (CFG_DWIDTH),
    .AWIDTH (CMD_AWIDTH)
  ) u_len_q (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_len_push),
    .i_wr_data (r_hold_len),
    .i_rd_en   (w_len_pop),
    .o_rd_data (w_len_head),
    .o_full    (w_len_full),
    .o_empty   (w_len_empty),
    .o_count   (w_len_count)
  );

  // Config serialiser: load a command, then walk SEL -> ADR -> LEN with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_hold_addr <= '0;
      r_hold_len  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_idle_issue) begin
            r_hold_addr <= w_head_addr;
            r_hold_len  <= w_head_len;
            r_state     <= S_SEL;
            r_cfg_valid <= 1'b1;
            r_cfg_addr  <= c_sel_addr;
            r_cfg_data  <= c_id;
          end
        end
        S_SEL: begin
          if (cfg_ready) begin
            r_state    <= S_ADR;
            r_cfg_addr <= c_data_addr;
            r_cfg_data <= r_hold_addr;
          end
        end
        S_ADR: begin
          if (cfg_ready) begin
            r_state    <= S_LEN;
            r_cfg_data <= r_hold_len;
          end
        end
        S_LEN: begin
          if (cfg_ready) begin
            if (w_chain) begin
              // Next command goes straight out with no idle cycle on the bus
              r_hold_addr <= w_head_addr;
              r_hold_len  <= w_head_len;
              r_state     <= S_SEL;
              r_cfg_addr  <= c_sel_addr;
              r_cfg_data  <= c_id;
            end else begin
              r_state     <= S_IDLE;
              r_cfg_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count consumed stream words against the oldest pending length; flag orphan beats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_len_pop;
      if (w_beat) begin
        if (w_len_empty) begin
          r_err <= 1'b1;
        end else if (w_len_pop) begin
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= w_cnt_inc;
        end
      end
    end
  end

  // Activity flag covering queued commands, an in-flight sequence and pending lengths
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_cmd_count != '0) || (r_state != S_IDLE) || !w_len_empty;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_read_cmd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_axis_read_cmd                                        |
// | Purpose  : Scoreboard bench for axis_read_cmd: directed scenarios  |
// |            plus randomized traffic against a queue-based model.    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_axis_read_cmd;

  logic        clk;
  logic        rst;
  logic [31:0] cmd_address;
  logic [31:0] cmd_length;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        strm_valid;
  logic        strm_ready;
  logic        done;
  logic        busy;
  logic        err_unexp;

  axis_read_cmd dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_address (cmd_address),
    .cmd_length  (cmd_length),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .strm_valid  (strm_valid),
    .strm_ready  (strm_ready),
    .done        (done),
    .busy        (busy),
    .err_unexp   (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        last;
  } beat_t;

  // Model state: expected config beats in order, and lengths the engine is working on
  beat_t       sb[$];
  logic [31:0] pend[$];
  int          beat_cyc[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_done   = 0;
  int          n_beats  = 0;
  int          cyc      = 0;
  bit          bg       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Advance one cycle; in background mode randomize the bus and stream handshakes
  task automatic step();
    @(posedge clk);
    #1;
    if (bg) begin
      cfg_ready  = ($urandom_range(0, 3) != 0);
      strm_ready = ($urandom_range(0, 1) != 0);
      strm_valid = (pend.size() != 0) && ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] l);
    cmd_address = a;
    cmd_length  = l;
    cmd_valid   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (cmd_ready) begin
        step();
        cmd_valid = 1'b0;
        return;
      end
      step();
    end
    cmd_valid = 1'b0;
    timeout("send_cmd");
  endtask

  task automatic drain();
    bg        = 1'b1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (sb.size() == 0 && pend.size() == 0 && busy == 1'b0) begin
        bg         = 1'b0;
        cfg_ready  = 1'b1;
        strm_valid = 1'b0;
        strm_ready = 1'b0;
        step();
        return;
      end
    end
    bg = 1'b0;
    strm_valid = 1'b0;
    timeout("drain");
  endtask

  // Monitor: compare every cycle against the model, then advance the model
  initial begin
    beat_t            e;
    longint unsigned  cnt;
    logic             exp_done;
    logic             exp_err;
    bit               prev_stall;
    logic [37:0]      prev_cfg;
    cnt = 0; exp_done = 1'b0; exp_err = 1'b0; prev_stall = 1'b0; prev_cfg = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        pend.delete();
        cnt        = 0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("done", done, exp_done);
        check("err_unexp", err_unexp, exp_err);
        if (done === 1'b1) n_done++;
        if (prev_stall) check("cfg_hold", {cfg_valid, cfg_addr, cfg_data}, prev_cfg);
        prev_stall = cfg_valid && !cfg_ready;
        prev_cfg   = {cfg_valid, cfg_addr, cfg_data};

        if (cmd_valid && cmd_ready && cmd_length != 0) begin
          sb.push_back('{a: 5'd23, d: 32'd1, last: 1'b0});
          sb.push_back('{a: 5'd24, d: cmd_address, last: 1'b0});
          sb.push_back('{a: 5'd24, d: cmd_length, last: 1'b1});
        end

        // Stream beats are judged against lengths already handed over before this edge
        exp_done = 1'b0;
        if (strm_valid && strm_ready) begin
          if (pend.size() == 0) begin
            exp_err = 1'b1;
          end else begin
            cnt++;
            if (cnt == longint'(pend[0])) begin
              exp_done = 1'b1;
              void'(pend.pop_front());
              cnt = 0;
            end
          end
        end

        if (cfg_valid && cfg_ready) begin
          n_beats++;
          beat_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL cfg_unexpected: actual=%0h/%0h required=none", cfg_addr, cfg_data);
          end else begin
            e = sb.pop_front();
            check("cfg_beat", {cfg_addr, cfg_data}, {e.a, e.d});
            if (e.last) pend.push_back(e.d);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int d0;
    int nb;
    rst = 1'b1; cmd_address = '0; cmd_length = '0; cmd_valid = 1'b0;
    cfg_ready = 1'b0; strm_valid = 1'b0; strm_ready = 1'b0;

    // Reset state
    step();
    check("rst_cmd_ready", cmd_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {cfg_valid, cfg_addr, cfg_data, done, busy, err_unexp}, 0);
    check("rst_cmd_ready_after", cmd_ready, 1);

    // Single command: beats at t+2..t+4, done after 16th word, busy falls next cycle
    step();
    cfg_ready = 1'b1;
    cmd_address = 32'h1000; cmd_length = 32'd16; cmd_valid = 1'b1;
    check("t1_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk); check("t1_t1_idle", cfg_valid, 0);
    step(); @(negedge clk); check("t1_sel", {cfg_valid, cfg_addr, cfg_data}, {1'b1, 5'd23, 32'd1});
    step(); @(negedge clk); check("t1_adr", {cfg_valid, cfg_addr, cfg_data}, {1'b1, 5'd24, 32'h1000});
    step(); @(negedge clk); check("t1_len", {cfg_valid, cfg_addr, cfg_data}, {1'b1, 5'd24, 32'd16});
    step();
    strm_valid = 1'b1; strm_ready = 1'b1;
    repeat (15) step();
    step();
    strm_valid = 1'b0; strm_ready = 1'b0;
    @(negedge clk); check("t1_done_busy", {done, busy}, 2'b11);
    step(); @(negedge clk); check("t1_after_done", {done, busy}, 2'b00);

    // Back-pressure in ADR: outputs frozen, exactly three beats
    cfg_ready = 1'b0;
    nb = n_beats;
    step();
    send_cmd(32'h2000, 32'd2);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (cfg_valid) seen = 1'b1; else step();
      end
      if (!seen) timeout("t2_sel");
    end
    step(); cfg_ready = 1'b1;
    step(); cfg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_stall", {cfg_valid, cfg_addr, cfg_data}, {1'b1, 5'd24, 32'h2000});
      step();
    end
    cfg_ready = 1'b1;
    repeat (3) step();
    strm_valid = 1'b1; strm_ready = 1'b1;
    repeat (2) step();
    strm_valid = 1'b0;
    repeat (3) step();
    check("t2_beats", n_beats - nb, 3);

    // Four back-to-back commands: contiguous beats; queue then fills
    b0 = beat_cyc.size();
    for (int i = 0; i < 4; i++) send_cmd(32'h100 * (i + 1), 32'd2);
    for (int k = 0; k < 30 && beat_cyc.size() < b0 + 12; k++) step();
    if (beat_cyc.size() < b0 + 12) timeout("t3_beats");
    else for (int k = 1; k < 12; k++) check("t3_contig", beat_cyc[b0 + k] - beat_cyc[b0], k);
    repeat (2) step();
    for (int i = 0; i < 4; i++) send_cmd(32'h900 + i, 32'd1);
    cmd_address = 32'hA00; cmd_length = 32'd1; cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t3_full", cmd_ready, 0);
      step();
    end
    bg = 1'b1;
    send_cmd(32'hA00, 32'd1);
    drain();

    // Two commands, toggled strm_ready: done after beat 3 and beat 5
    d0 = n_done;
    send_cmd(32'h3000, 32'd3);
    send_cmd(32'h3100, 32'd2);
    repeat (8) step();
    begin
      int beats = 0;
      for (int k = 0; k < 20 && beats < 5; k++) begin
        strm_valid = 1'b1;
        strm_ready = k[0];
        if (strm_ready) beats++;
        step();
      end
    end
    strm_valid = 1'b0; strm_ready = 1'b0;
    repeat (3) step();
    check("t4_done_count", n_done - d0, 2);

    // Randomized traffic, including zero-length commands
    bg = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_cmd($urandom, 32'($urandom_range(0, 6)));
    end
    drain();

    // Orphan stream beat sets the sticky error
    strm_valid = 1'b1; strm_ready = 1'b1;
    step();
    strm_valid = 1'b0; strm_ready = 1'b0;
    repeat (3) step();
    @(negedge clk); check("t5_err", err_unexp, 1);

    // Maximum length: stays pending, no done
    step();
    send_cmd(32'h7000, 32'hFFFF_FFFF);
    repeat (6) step();
    strm_valid = 1'b1; strm_ready = 1'b1;
    repeat (20) step();
    strm_valid = 1'b0; strm_ready = 1'b0;
    step();
    @(negedge clk); check("t5_big_busy", busy, 1);

    // Reset in LEN with cfg_ready low, then a fresh command
    step();
    cfg_ready = 1'b0;
    send_cmd(32'h4000, 32'd5);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (cfg_valid) seen = 1'b1; else step();
      end
      if (!seen) timeout("t6_sel");
    end
    step(); cfg_ready = 1'b1;
    step();
    step(); cfg_ready = 1'b0;
    @(negedge clk); check("t6_in_len", {cfg_valid, cfg_addr, cfg_data}, {1'b1, 5'd24, 32'd5});
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk); check("t6_after_rst", {cfg_valid, busy, cmd_ready}, 3'b001);
    step(); @(negedge clk); check("t6_idle", {cfg_valid, busy, err_unexp}, 3'b000);
    cfg_ready = 1'b1;
    step();
    send_cmd(32'h5000, 32'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
